// File: rtl/tdc_pkg.sv
// Shared TDC definitions: measurement FSM encoding and default coarse-count width,
// reused by the coarse-time, fine-time and readout stages.
package tdc_pkg;

    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ARMED    = 2'd1,
        ST_COUNTING = 2'd2,
        ST_DONE     = 2'd3
    } tdc_state_e;

    function automatic logic is_busy(input tdc_state_e s);
        return (s == ST_ARMED) || (s == ST_COUNTING);
    endfunction

endpackage

// File: rtl/pulse_sync.sv
// Brings an asynchronous (possibly sub-cycle) rising edge into the clk domain as a
// single-cycle event pulse, via a toggle flop, a 2-FF synchronizer and an edge detector.
module pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic event_pulse
);

    logic toggle;
    (* ASYNC_REG = "TRUE" *) logic sync_p0;
    (* ASYNC_REG = "TRUE" *) logic sync_p1;
    logic sync_p2;

    // The toggle captures edges too short for clk to sample directly.
    always_ff @(posedge async_in or posedge rst) begin
        if (rst) begin
            toggle <= 1'b0;
        end else begin
            toggle <= ~toggle;
        end
    end

    // Stage p0/p1: metastability filter; stage p2: previous value for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= toggle;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign event_pulse = sync_p1 ^ sync_p2;

endmodule

// File: rtl/interval_counter.sv
// Coarse-time TDC stage: counts whole clk cycles between synchronized start and stop
// events, single-shot per arm, with saturation and arm-to-start timeout reporting.
module interval_counter
    import tdc_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             arm,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             overflow,
    output logic             timeout,
    output logic             result_valid,
    input  logic             result_ready
);

    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);

    function automatic logic [CNT_W-1:0] cnt_sat();
        return '1;
    endfunction

    function automatic logic cnt_at_sat(input logic [CNT_W-1:0] v);
        return v == cnt_sat();
    endfunction

    tdc_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic [TO_W-1:0]  tcnt, tcnt_nxt, tcnt_inc;
    logic [CNT_W-1:0] result_nxt;
    logic             ovf_nxt, to_nxt;
    logic             start_evt, stop_evt;

    // Identical paths keep the start/stop relative latency equal.
    pulse_sync u_start_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (start),
        .event_pulse(start_evt)
    );

    pulse_sync u_stop_sync (
        .clk        (clk),
        .rst        (rst),
        .async_in   (stop),
        .event_pulse(stop_evt)
    );

    assign cnt_inc  = cnt + 1'b1;
    assign tcnt_inc = tcnt + 1'b1;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        tcnt_nxt   = tcnt;
        result_nxt = result;
        ovf_nxt    = overflow;
        to_nxt     = timeout;
        unique case (state)
            ST_IDLE: begin
                if (arm) begin
                    state_nxt  = ST_ARMED;
                    cnt_nxt    = '0;
                    tcnt_nxt   = '0;
                    result_nxt = '0;
                    ovf_nxt    = 1'b0;
                    to_nxt     = 1'b0;
                end
            end
            ST_ARMED: begin
                tcnt_nxt = tcnt_inc;
                if (start_evt && stop_evt) begin
                    state_nxt  = ST_DONE;
                    result_nxt = '0;
                end else if (start_evt) begin
                    state_nxt = ST_COUNTING;
                    cnt_nxt   = '0;
                end else if ((TIMEOUT != 0) && (tcnt_inc == TO_LIMIT)) begin
                    state_nxt  = ST_DONE;
                    result_nxt = '0;
                    to_nxt     = 1'b1;
                end
            end
            ST_COUNTING: begin
                cnt_nxt = cnt_inc;
                // A stop landing exactly on the saturation value is a valid measurement.
                if (stop_evt) begin
                    state_nxt  = ST_DONE;
                    result_nxt = cnt_inc;
                end else if (cnt_at_sat(cnt_inc)) begin
                    state_nxt  = ST_DONE;
                    result_nxt = cnt_sat();
                    ovf_nxt    = 1'b1;
                end
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tcnt     <= '0;
            result   <= '0;
            overflow <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            tcnt     <= tcnt_nxt;
            result   <= result_nxt;
            overflow <= ovf_nxt;
            timeout  <= to_nxt;
        end
    end

    assign busy         = is_busy(state);
    assign result_valid = (state == ST_DONE);

endmodule

// File: tb/tb_interval_counter.sv
// Bench for interval_counter: async start/stop pulses launched at random phases,
// results compared against cycle counts taken from the bench's own clock edge index.
module tb_interval_counter;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 20;
    localparam int MAXV    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic             arm = 1'b0;
    logic             result_ready = 1'b0;
    logic             busy, overflow, timeout, result_valid;
    logic [CNT_W-1:0] result;

    int checks   = 0;
    int failures = 0;
    int edge_cnt = 0;

    interval_counter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .arm         (arm),
        .busy        (busy),
        .result      (result),
        .overflow    (overflow),
        .timeout     (timeout),
        .result_valid(result_valid),
        .result_ready(result_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    // Pulse start and/or stop inside the cycle following the next edge, away from
    // any clk edge; 'at' is the index of that edge.
    task automatic launch(input bit s, input bit p, output int at);
        @(posedge clk);
        #(1 + $urandom_range(0, 4));
        at = edge_cnt;
        if (s) start = 1'b1;
        if (p) stop = 1'b1;
        #2;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic flush();
        idle(6);
        #1;
    endtask

    task automatic do_arm();
        @(posedge clk);
        #1 arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cyc, output bit ok);
        cyc = 0;
        while (result_valid !== 1'b1 && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        ok = (result_valid === 1'b1);
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(posedge clk);
        #1 result_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, overflow, timeout, result_valid, result} !== '0) begin
            failures++;
            $display("FAIL reset_values: got busy=%b ovf=%b to=%b vld=%b res=%0d expected all 0",
                     busy, overflow, timeout, result_valid, result);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int ts, tp, cyc, exp_n;
        bit ok;
        flush();
        do_arm();
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy_after_arm: got %b expected 1", busy);
        end
        launch(1, 0, ts);
        idle(9);
        launch(0, 1, tp);
        exp_n = tp - ts;
        wait_valid(30, cyc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL basic_valid: result_valid not seen within 30 cycles");
        end
        checks++;
        if (result !== CNT_W'(exp_n) || exp_n != 10) begin
            failures++;
            $display("FAIL basic_result: got %0d expected %0d (nominal 10)", result, exp_n);
        end
        checks++;
        if (overflow !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL basic_flags: got ovf=%b to=%b expected 0 0", overflow, timeout);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (result_valid !== 1'b1 || result !== CNT_W'(exp_n) || overflow !== 1'b0 ||
                timeout !== 1'b0) begin
                failures++;
                $display("FAIL basic_hold[%0d]: got vld=%b res=%0d ovf=%b to=%b expected 1 %0d 0 0",
                         i, result_valid, result, overflow, timeout, exp_n);
            end
        end
        accept();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_accept: got vld=%b busy=%b expected 0 0", result_valid, busy);
        end
    endtask

    task automatic test_simultaneous();
        int ts, cyc;
        bit ok;
        flush();
        do_arm();
        launch(1, 1, ts);
        wait_valid(30, cyc, ok);
        checks++;
        if (!ok || result !== '0 || overflow !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL simultaneous: got vld=%b res=%0d ovf=%b to=%b expected 1 0 0 0",
                     result_valid, result, overflow, timeout);
        end
        accept();
    endtask

    task automatic test_overflow();
        int ts, cyc;
        bit ok;
        flush();
        do_arm();
        launch(1, 0, ts);
        wait_valid(40, cyc, ok);
        checks++;
        if (!ok || cyc < MAXV + 3 || cyc > MAXV + 4) begin
            failures++;
            $display("FAIL overflow_latency: got vld=%b after %0d cycles expected %0d..%0d",
                     result_valid, cyc, MAXV + 3, MAXV + 4);
        end
        checks++;
        if (result !== CNT_W'(MAXV) || overflow !== 1'b1 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL overflow_value: got res=%0d ovf=%b to=%b expected %0d 1 0",
                     result, overflow, timeout, MAXV);
        end
        accept();
    endtask

    task automatic test_timeout();
        int cyc;
        bit ok;
        flush();
        do_arm();
        wait_valid(40, cyc, ok);
        checks++;
        if (!ok || cyc != TIMEOUT) begin
            failures++;
            $display("FAIL timeout_latency: got vld=%b after %0d cycles expected %0d",
                     result_valid, cyc, TIMEOUT);
        end
        checks++;
        if (timeout !== 1'b1 || result !== '0 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL timeout_value: got to=%b res=%0d ovf=%b expected 1 0 0",
                     timeout, result, overflow);
        end
        accept();
    endtask

    task automatic test_stop_before_start();
        int t0, ts, tp, cyc;
        bit ok;
        flush();
        do_arm();
        launch(0, 1, t0);
        idle(2);
        launch(1, 0, ts);
        idle(4);
        launch(0, 1, tp);
        wait_valid(30, cyc, ok);
        checks++;
        if (!ok || result !== CNT_W'(tp - ts) || overflow !== 1'b0) begin
            failures++;
            $display("FAIL stop_before_start: got vld=%b res=%0d ovf=%b expected 1 %0d 0",
                     result_valid, result, overflow, tp - ts);
        end
        accept();
    endtask

    task automatic test_second_start();
        int ts, t2, tp, cyc;
        bit ok;
        flush();
        do_arm();
        launch(1, 0, ts);
        idle(3);
        launch(1, 0, t2);
        idle(3);
        launch(0, 1, tp);
        wait_valid(30, cyc, ok);
        checks++;
        if (!ok || result !== CNT_W'(tp - ts) || overflow !== 1'b0) begin
            failures++;
            $display("FAIL second_start: got vld=%b res=%0d ovf=%b expected 1 %0d 0",
                     result_valid, result, overflow, tp - ts);
        end
        accept();
    endtask

    task automatic test_idle_done_ignored();
        int ta, ts, tp, cyc, exp_n;
        bit ok;
        flush();
        launch(1, 0, ta);
        idle(1);
        launch(0, 1, ta);
        idle(5);
        #1;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_events: got vld=%b busy=%b expected 0 0", result_valid, busy);
        end
        do_arm();
        launch(1, 0, ts);
        idle(4);
        launch(0, 1, tp);
        exp_n = tp - ts;
        wait_valid(30, cyc, ok);
        checks++;
        if (!ok || result !== CNT_W'(exp_n)) begin
            failures++;
            $display("FAIL done_measure: got vld=%b res=%0d expected 1 %0d", result_valid, result, exp_n);
        end
        launch(1, 0, ta);
        idle(2);
        #1 arm = 1'b1;
        @(posedge clk);
        #1 arm = 1'b0;
        launch(0, 1, ta);
        idle(5);
        #1;
        checks++;
        if (result_valid !== 1'b1 || busy !== 1'b0 || result !== CNT_W'(exp_n) ||
            overflow !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL done_events: got vld=%b busy=%b res=%0d ovf=%b to=%b expected 1 0 %0d 0 0",
                     result_valid, busy, result, overflow, timeout, exp_n);
        end
        accept();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_accept: got vld=%b busy=%b expected 0 0", result_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        int ts, tp, cyc;
        bit ok;
        flush();
        do_arm();
        launch(1, 0, ts);
        idle(4);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({busy, overflow, timeout, result_valid, result} !== '0) begin
            failures++;
            $display("FAIL reset_mid_async: got busy=%b ovf=%b to=%b vld=%b res=%0d expected all 0",
                     busy, overflow, timeout, result_valid, result);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        flush();
        checks++;
        if ({busy, result_valid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_mid_release: got busy=%b vld=%b expected 0 0", busy, result_valid);
        end
        do_arm();
        launch(1, 0, ts);
        idle(6);
        launch(0, 1, tp);
        wait_valid(30, cyc, ok);
        checks++;
        if (!ok || result !== CNT_W'(tp - ts) || overflow !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_remeasure: got vld=%b res=%0d ovf=%b to=%b expected 1 %0d 0 0",
                     result_valid, result, overflow, timeout, tp - ts);
        end
        accept();
    endtask

    task automatic test_random();
        int ts, tp, cyc, n, d, exp_res;
        bit ok, exp_ovf;
        for (int i = 0; i < 8; i++) begin
            n = (i == 0) ? MAXV : int'($urandom_range(1, MAXV + 3));
            flush();
            do_arm();
            launch(1, 0, ts);
            idle(n - 1);
            launch(0, 1, tp);
            exp_ovf = (tp - ts) > MAXV;
            exp_res = exp_ovf ? MAXV : (tp - ts);
            wait_valid(40, cyc, ok);
            checks++;
            if (!ok || result !== CNT_W'(exp_res) || overflow !== exp_ovf || timeout !== 1'b0) begin
                failures++;
                $display("FAIL random[%0d]: got vld=%b res=%0d ovf=%b to=%b expected 1 %0d %b 0",
                         i, result_valid, result, overflow, timeout, exp_res, exp_ovf);
            end
            d = int'($urandom_range(0, 3));
            for (int j = 0; j < d; j++) begin
                @(posedge clk);
                #1;
                checks++;
                if (result_valid !== 1'b1 || result !== CNT_W'(exp_res)) begin
                    failures++;
                    $display("FAIL random_hold[%0d]: got vld=%b res=%0d expected 1 %0d",
                             i, result_valid, result, exp_res);
                end
            end
            accept();
            checks++;
            if (result_valid !== 1'b0) begin
                failures++;
                $display("FAIL random_accept[%0d]: got vld=%b expected 0", i, result_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_simultaneous();
        test_overflow();
        test_timeout();
        test_stop_before_start();
        test_second_start();
        test_idle_done_ignored();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
